// File: rtl/riscv_load_unit_pkg.sv
// Shared type codes and FSM encoding for the data-RAM load unit.
package riscv_load_unit_pkg;

  localparam int unsigned LdTypeW = 3;

  // Load type codes follow the RISC-V funct3 encoding; any other value decodes as LW.
  typedef enum logic [LdTypeW-1:0] {
    LdLb  = 3'b000,
    LdLh  = 3'b001,
    LdLw  = 3'b010,
    LdLbu = 3'b100,
    LdLhu = 3'b101
  } ld_type_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StWait = 2'b01,
    StResp = 2'b10
  } ldu_state_e;

endpackage

// File: rtl/riscv_load_extract.sv
// Byte/halfword lane selection, sign/zero extension and alignment check for one load.
module riscv_load_extract
  import riscv_load_unit_pkg::*;
(
  input  logic [2:0]  i_type,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_word,
  output logic [31:0] o_data,
  output logic        o_misaligned
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Little-endian lanes: byte n is bits [8n+7:8n].
  assign w_byte = i_word[{i_offset, 3'b000} +: 8];
  assign w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];

  // Decode the load type into extended data and the misaligned flag.
  always_comb begin
    o_data       = i_word;
    o_misaligned = 1'b0;
    case (i_type)
      LdLb:  o_data = {{24{w_byte[7]}}, w_byte};
      LdLbu: o_data = {24'h0, w_byte};
      LdLh: begin
        o_data       = {{16{w_half[15]}}, w_half};
        o_misaligned = i_offset[0];
      end
      LdLhu: begin
        o_data       = {16'h0, w_half};
        o_misaligned = i_offset[0];
      end
      default: begin
        o_data       = i_word;
        o_misaligned = |i_offset;
      end
    endcase
  end

endmodule

// File: rtl/riscv_load_unit.sv
// Load unit: accepts MEM-stage loads, reads the synchronous data RAM, returns extended data.
module riscv_load_unit
  import riscv_load_unit_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned ADDR_W       = 14
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_mem_en,
  input  logic              i_ld_req_valid,
  output logic              o_ld_req_ready,
  input  logic [2:0]        i_ld_type,
  input  logic [31:0]       i_ld_addr,
  input  logic [4:0]        i_ld_rd,
  output logic              o_mem_rd_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [31:0]       i_mem_rdata,
  output logic              o_ld_rsp_valid,
  input  logic              i_ld_rsp_ready,
  output logic [31:0]       o_ld_rsp_data,
  output logic [4:0]        o_ld_rsp_rd,
  output logic              o_ld_rsp_misaligned
);

  localparam int unsigned CntW = $clog2(READ_LATENCY + 1);

  ldu_state_e        r_state, w_state_nxt;
  logic [CntW-1:0]   r_cnt, w_cnt_nxt;
  logic [2:0]        r_type, w_type_nxt;
  logic [1:0]        r_off, w_off_nxt;
  logic [4:0]        r_rd, w_rd_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic              r_mem_rd_en, w_mem_rd_en_nxt;
  logic [31:0]       r_rsp_data, w_rsp_data_nxt;
  logic              r_rsp_mis, w_rsp_mis_nxt;

  logic              w_req_ready;
  logic              w_accept;
  logic [2:0]        w_ext_type;
  logic [1:0]        w_ext_off;
  logic [31:0]       w_ext_data;
  logic              w_ext_mis;
  logic              w_unused_addr;

  // Address bits above the RAM word range are intentionally dropped.
  assign w_unused_addr = ^i_ld_addr[31:ADDR_W+2];

  assign w_req_ready = (r_state == StIdle) & i_mem_en;
  assign w_accept    = w_req_ready & i_ld_req_valid;

  // In IDLE the extractor judges alignment of the incoming request; later it decodes the capture.
  assign w_ext_type = (r_state == StIdle) ? i_ld_type : r_type;
  assign w_ext_off  = (r_state == StIdle) ? i_ld_addr[1:0] : r_off;

  riscv_load_extract u_extract (
    .i_type       (w_ext_type),
    .i_offset     (w_ext_off),
    .i_word       (i_mem_rdata),
    .o_data       (w_ext_data),
    .o_misaligned (w_ext_mis)
  );

  // Next-state and datapath updates for the IDLE -> WAIT -> RESP sequence.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_type_nxt      = r_type;
    w_off_nxt       = r_off;
    w_rd_nxt        = r_rd;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_rd_en_nxt = 1'b0;
    w_rsp_data_nxt  = r_rsp_data;
    w_rsp_mis_nxt   = r_rsp_mis;
    case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_type_nxt = i_ld_type;
          w_off_nxt  = i_ld_addr[1:0];
          w_rd_nxt   = i_ld_rd;
          if (w_ext_mis) begin
            w_rsp_data_nxt = 32'h0;
            w_rsp_mis_nxt  = 1'b1;
            w_state_nxt    = StResp;
          end else begin
            w_mem_addr_nxt  = i_ld_addr[ADDR_W+1:2];
            w_mem_rd_en_nxt = 1'b1;
            w_cnt_nxt       = CntW'(READ_LATENCY);
            w_rsp_mis_nxt   = 1'b0;
            w_state_nxt     = StWait;
          end
        end
      end
      StWait: begin
        // Last wait cycle: RAM data is valid now, so register the extracted result.
        if (r_cnt == CntW'(1)) begin
          w_cnt_nxt      = '0;
          w_rsp_data_nxt = w_ext_data;
          w_rsp_mis_nxt  = 1'b0;
          w_state_nxt    = StResp;
        end else begin
          w_cnt_nxt = r_cnt - CntW'(1);
        end
      end
      StResp: begin
        if (i_ld_rsp_ready) begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_type      <= '0;
      r_off       <= '0;
      r_rd        <= '0;
      r_mem_addr  <= '0;
      r_mem_rd_en <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_mis   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_type      <= w_type_nxt;
      r_off       <= w_off_nxt;
      r_rd        <= w_rd_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_rd_en <= w_mem_rd_en_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_rsp_mis   <= w_rsp_mis_nxt;
    end
  end

  assign o_ld_req_ready      = w_req_ready;
  assign o_mem_rd_en         = r_mem_rd_en;
  assign o_mem_addr          = r_mem_addr;
  assign o_ld_rsp_valid      = (r_state == StResp);
  assign o_ld_rsp_data       = r_rsp_data;
  assign o_ld_rsp_rd         = r_rd;
  assign o_ld_rsp_misaligned = r_rsp_mis;

endmodule

// File: tb/tb_riscv_load_unit.sv
// Self-checking bench for riscv_load_unit: latency-1 and latency-3 instances.
module tb_riscv_load_unit;

  localparam logic [31:0] Junk = 32'hA5C3_3C5A;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rst_n3, mem_en;
  logic        req_valid, req_valid3, rsp_ready, rsp_ready3;
  logic [2:0]  ld_type;
  logic [31:0] ld_addr;
  logic [4:0]  ld_rd;

  logic        req_ready, rd_en, rsp_valid, rsp_mis;
  logic [13:0] maddr;
  logic [31:0] rdata, rsp_data;
  logic [4:0]  rsp_rd;

  logic        req_ready3, rd_en3, rsp_valid3, rsp_mis3;
  logic [13:0] maddr3;
  logic [31:0] rdata3, rsp_data3;
  logic [4:0]  rsp_rd3;

  logic [31:0] ram [16];

  int n_checks = 0;
  int n_fail   = 0;

  // Latency-1 RAM: data valid only in the cycle the read strobe is high.
  assign rdata = rd_en ? ram[maddr[3:0]] : Junk;

  // Latency-3 RAM: data valid only two cycles after the read strobe.
  logic        p1_v = 1'b0, p2_v = 1'b0;
  logic [13:0] p1_a = '0, p2_a = '0;
  always @(posedge clk) begin
    p1_v <= rd_en3;
    p1_a <= maddr3;
    p2_v <= p1_v;
    p2_a <= p1_a;
  end
  assign rdata3 = p2_v ? ram[p2_a[3:0]] : Junk;

  riscv_load_unit #(.READ_LATENCY(1), .ADDR_W(14)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_mem_en(mem_en),
    .i_ld_req_valid(req_valid), .o_ld_req_ready(req_ready),
    .i_ld_type(ld_type), .i_ld_addr(ld_addr), .i_ld_rd(ld_rd),
    .o_mem_rd_en(rd_en), .o_mem_addr(maddr), .i_mem_rdata(rdata),
    .o_ld_rsp_valid(rsp_valid), .i_ld_rsp_ready(rsp_ready),
    .o_ld_rsp_data(rsp_data), .o_ld_rsp_rd(rsp_rd), .o_ld_rsp_misaligned(rsp_mis)
  );

  riscv_load_unit #(.READ_LATENCY(3), .ADDR_W(14)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n3), .i_mem_en(mem_en),
    .i_ld_req_valid(req_valid3), .o_ld_req_ready(req_ready3),
    .i_ld_type(ld_type), .i_ld_addr(ld_addr), .i_ld_rd(ld_rd),
    .o_mem_rd_en(rd_en3), .o_mem_addr(maddr3), .i_mem_rdata(rdata3),
    .o_ld_rsp_valid(rsp_valid3), .i_ld_rsp_ready(rsp_ready3),
    .o_ld_rsp_data(rsp_data3), .o_ld_rsp_rd(rsp_rd3), .o_ld_rsp_misaligned(rsp_mis3)
  );

  // Reference: arithmetic lane pick and extension straight from the load rules.
  function automatic void model_load(input logic [2:0] t, input logic [31:0] a,
                                     input logic [31:0] w, output logic [31:0] d,
                                     output logic m);
    longint v;
    int     off;
    off = int'(a % 4);
    case (t)
      3'd0: begin m = 1'b0; v = longint'((w >> (8 * off)) % 256); if (v > 127) v -= 256; end
      3'd4: begin m = 1'b0; v = longint'((w >> (8 * off)) % 256); end
      3'd1: begin
        m = (off % 2) != 0;
        v = longint'((w >> (16 * (off / 2))) % 65536);
        if (v > 32767) v -= 65536;
      end
      3'd5: begin m = (off % 2) != 0; v = longint'((w >> (16 * (off / 2))) % 65536); end
      default: begin m = (off != 0); v = longint'(w); end
    endcase
    if (m) v = 0;
    d = v[31:0];
  endfunction

  // Drive one load on the latency-1 instance with the consumer always ready.
  task automatic run_load(input logic [2:0] t, input logic [31:0] a, input logic [4:0] r,
                          output logic [31:0] d, output logic m, output logic [4:0] rr,
                          output int lat, output int pulses, output logic [13:0] sa,
                          output logic ok);
    int guard;
    ok = 1'b0; lat = 0; pulses = 0; sa = '0; d = '0; m = 1'b0; rr = '0; guard = 0;
    @(negedge clk);
    ld_type = t; ld_addr = a; ld_rd = r; req_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    while (!req_ready && guard < 20) begin
      @(negedge clk); #1; guard++;
    end
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (rd_en) begin pulses++; sa = maddr; end
      if (rsp_valid) begin
        d = rsp_data; m = rsp_mis; rr = rsp_rd; lat = i; ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b1; rst_n3 = 1'b1; mem_en = 1'b0;
    req_valid = 1'b0; req_valid3 = 1'b0; rsp_ready = 1'b0; rsp_ready3 = 1'b0;
    ld_type = '0; ld_addr = '0; ld_rd = '0;
    #1 rst_n = 1'b0; rst_n3 = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({req_ready, rd_en, maddr, rsp_valid, rsp_data, rsp_rd, rsp_mis} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs_l1: got rdy=%b en=%b addr=%h v=%b d=%h rd=%h mis=%b required all 0",
               req_ready, rd_en, maddr, rsp_valid, rsp_data, rsp_rd, rsp_mis);
    end
    n_checks++;
    if ({req_ready3, rd_en3, maddr3, rsp_valid3, rsp_data3, rsp_rd3, rsp_mis3} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs_l3: got rdy=%b en=%b addr=%h v=%b d=%h rd=%h mis=%b required all 0",
               req_ready3, rd_en3, maddr3, rsp_valid3, rsp_data3, rsp_rd3, rsp_mis3);
    end
    rst_n = 1'b1; rst_n3 = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b0) begin
      n_fail++; $display("FAIL ready_mem_en_low: got %b required 0", req_ready);
    end
    mem_en = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b1 || req_ready3 !== 1'b1) begin
      n_fail++; $display("FAIL ready_idle: got %b/%b required 1/1", req_ready, req_ready3);
    end
  endtask

  task automatic test_directed();
    logic [2:0]  types [7] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd2, 3'd1};
    logic [31:0] addrs [7] = '{32'h1003, 32'h1003, 32'h1002, 32'h1000, 32'h1000, 32'h1002, 32'h1001};
    logic [31:0] exps  [7] = '{32'hFFFF_FF81, 32'h0000_0081, 32'hFFFF_8180, 32'h0000_7F01,
                               32'h8180_7F01, 32'h0, 32'h0};
    logic        mise  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] d; logic m; logic [4:0] rr; int lat, pulses; logic [13:0] sa; logic ok;
    ram[0] = 32'h8180_7F01;
    for (int i = 0; i < 7; i++) begin
      run_load(types[i], addrs[i], 5'(i + 1), d, m, rr, lat, pulses, sa, ok);
      n_checks++;
      if (ok !== 1'b1) begin n_fail++; $display("FAIL dir%0d_timeout: no response", i); end
      n_checks++;
      if (d !== exps[i] || m !== mise[i]) begin
        n_fail++; $display("FAIL dir%0d_data: got %h mis=%b required %h mis=%b", i, d, m, exps[i], mise[i]);
      end
      n_checks++;
      if (rr !== 5'(i + 1)) begin n_fail++; $display("FAIL dir%0d_rd: got %0d required %0d", i, rr, i + 1); end
      n_checks++;
      if (lat !== (mise[i] ? 1 : 2) || pulses !== (mise[i] ? 0 : 1)) begin
        n_fail++; $display("FAIL dir%0d_timing: got lat=%0d pulses=%0d required lat=%0d pulses=%0d",
                           i, lat, pulses, mise[i] ? 1 : 2, mise[i] ? 0 : 1);
      end
      if (!mise[i]) begin
        n_checks++;
        if (sa !== 14'h400) begin n_fail++; $display("FAIL dir%0d_addr: got %h required 400", i, sa); end
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] t; logic [31:0] a, w, ed, d; logic [4:0] r, rr; logic em, m, ok;
    int lat, pulses; logic [13:0] sa;
    for (int i = 0; i < 16; i++) ram[i] = $urandom;
    for (int i = 0; i < 48; i++) begin
      t = 3'($urandom_range(7)); a = $urandom; r = 5'($urandom);
      w = ram[a[5:2]];
      model_load(t, a, w, ed, em);
      run_load(t, a, r, d, m, rr, lat, pulses, sa, ok);
      n_checks++;
      if (ok !== 1'b1 || d !== ed || m !== em || rr !== r) begin
        n_fail++;
        $display("FAIL rand%0d t=%0d a=%h: got ok=%b d=%h mis=%b rd=%0d required d=%h mis=%b rd=%0d",
                 i, t, a, ok, d, m, rr, ed, em, r);
      end
      n_checks++;
      if (lat !== (em ? 1 : 2) || pulses !== (em ? 0 : 1) || (!em && sa !== a[15:2])) begin
        n_fail++;
        $display("FAIL rand%0d_timing: got lat=%0d pulses=%0d addr=%h required lat=%0d pulses=%0d addr=%h",
                 i, lat, pulses, sa, em ? 1 : 2, em ? 0 : 1, a[15:2]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] w; logic [31:0] cap; int guard;
    w = $urandom; ram[2] = w;
    @(negedge clk);
    ld_type = 3'd2; ld_addr = 32'h0000_2008; ld_rd = 5'd17; req_valid = 1'b1; rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    guard = 0;
    while (!rsp_valid && guard < 10) begin @(negedge clk); guard++; end
    n_checks++;
    if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_timeout: valid=%b required 1", rsp_valid); end
    cap = rsp_data;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== w || rsp_rd !== 5'd17 || req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got v=%b d=%h rd=%0d rdy=%b required v=1 d=%h rd=17 rdy=0",
                 i, rsp_valid, rsp_data, rsp_rd, req_ready, w);
      end
      @(negedge clk);
    end
    n_checks++;
    if (cap !== w) begin n_fail++; $display("FAIL bp_data: got %h required %h", cap, w); end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: got v=%b rdy=%b required v=0 rdy=1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_mem_en();
    logic [31:0] w; int guard;
    w = $urandom; ram[3] = w;
    @(negedge clk);
    mem_en = 1'b0; req_valid = 1'b1; rsp_ready = 1'b1;
    ld_type = 3'd2; ld_addr = 32'h0000_000C; ld_rd = 5'd9;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (req_ready !== 1'b0 || rd_en !== 1'b0 || rsp_valid !== 1'b0) begin
        n_fail++; $display("FAIL memen_block%0d: got rdy=%b en=%b v=%b required 0/0/0", i, req_ready, rd_en, rsp_valid);
      end
      @(negedge clk);
    end
    mem_en = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL memen_ready: got %b required 1", req_ready); end
    @(negedge clk);
    req_valid = 1'b0;
    n_checks++;
    if (rd_en !== 1'b1) begin n_fail++; $display("FAIL memen_rd_en: got %b required 1", rd_en); end
    mem_en = 1'b0;
    guard = 0;
    while (!rsp_valid && guard < 10) begin @(negedge clk); guard++; end
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== w || rsp_rd !== 5'd9) begin
      n_fail++; $display("FAIL memen_inflight: got v=%b d=%h rd=%0d required v=1 d=%h rd=9", rsp_valid, rsp_data, rsp_rd, w);
    end
    req_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      n_checks++;
      if (req_ready !== 1'b0 || rd_en !== 1'b0 || rsp_valid !== 1'b0) begin
        n_fail++; $display("FAIL memen_after%0d: got rdy=%b en=%b v=%b required 0/0/0", i, req_ready, rd_en, rsp_valid);
      end
    end
    req_valid = 1'b0; mem_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, ed; logic em; int last, pulses, resps; logic prev;
    ram[7] = $urandom;
    a = 32'h0000_001C + 32'($urandom_range(3));
    model_load(3'd4, a, ram[7], ed, em);
    last = -1; pulses = 0; resps = 0; prev = 1'b0;
    @(negedge clk);
    ld_type = 3'd4; ld_addr = a; ld_rd = 5'd3; req_valid = 1'b1; rsp_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (rd_en) begin
        if (last >= 0) begin
          n_checks++;
          if (c - last != 3) begin n_fail++; $display("FAIL b2b_interval: got %0d required 3", c - last); end
        end
        last = c; pulses++;
      end
      if (rsp_valid) begin
        resps++;
        n_checks++;
        if (rsp_data !== ed || rsp_rd !== 5'd3) begin
          n_fail++; $display("FAIL b2b_data: got %h rd=%0d required %h rd=3", rsp_data, rsp_rd, ed);
        end
      end
    end
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (pulses != 10 || resps != 10) begin
      n_fail++; $display("FAIL b2b_count: got pulses=%0d resps=%0d required 10/10", pulses, resps);
    end
  endtask

  task automatic test_latency3_reset();
    logic [31:0] w; int lat, pulses; logic bad;
    w = $urandom | 32'h1; ram[5] = w;
    lat = 0; pulses = 0;
    @(negedge clk);
    ld_type = 3'd2; ld_addr = 32'h0000_0014; ld_rd = 5'd9; req_valid3 = 1'b1; rsp_ready3 = 1'b1;
    #1;
    n_checks++;
    if (req_ready3 !== 1'b1) begin n_fail++; $display("FAIL l3_ready: got %b required 1", req_ready3); end
    @(negedge clk);
    req_valid3 = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (rd_en3) pulses++;
      if (rsp_valid3) begin lat = i; break; end
      @(negedge clk);
    end
    n_checks++;
    if (lat != 4 || pulses != 1 || rsp_data3 !== w) begin
      n_fail++; $display("FAIL l3_load: got lat=%0d pulses=%0d d=%h required lat=4 pulses=1 d=%h", lat, pulses, rsp_data3, w);
    end
    @(negedge clk);
    ld_type = 3'd1; ld_addr = 32'h0000_0016; req_valid3 = 1'b1;
    @(negedge clk);
    req_valid3 = 1'b0;
    @(negedge clk);
    mem_en = 1'b0;
    rst_n3 = 1'b0;
    #1;
    n_checks++;
    if ({req_ready3, rd_en3, maddr3, rsp_valid3, rsp_data3, rsp_rd3, rsp_mis3} !== '0) begin
      n_fail++;
      $display("FAIL l3_async_reset: got rdy=%b en=%b addr=%h v=%b d=%h rd=%h mis=%b required all 0",
               req_ready3, rd_en3, maddr3, rsp_valid3, rsp_data3, rsp_rd3, rsp_mis3);
    end
    @(negedge clk);
    rst_n3 = 1'b1; mem_en = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid3 !== 1'b0 || rd_en3 !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad !== 1'b0) begin n_fail++; $display("FAIL l3_no_resp_after_reset: got activity=%b required 0", bad); end
    n_checks++;
    if (req_ready3 !== 1'b1) begin n_fail++; $display("FAIL l3_idle_after_reset: got %b required 1", req_ready3); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_mem_en();
    test_back_to_back();
    test_latency3_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
